// File: rtl/adder_test_ctrl.sv
// Drives pseudo-random operand pairs into a registered adder and checks each sum LAT cycles later.
// One vector per cycle while busy; no backpressure, abort stops issue on the next edge.
module adder_test_ctrl #(
  parameter int WL       = 8,
  parameter int LAT      = 1,
  parameter int NUM_VECT = 256
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          abort_i,
  output logic          add_en_o,
  output logic [WL-1:0] op_x_o,
  output logic [WL-1:0] op_y_o,
  input  logic [WL-1:0] add_result_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          aborted_o,
  output logic [15:0]   err_cnt_o,
  output logic [15:0]   vect_cnt_o,
  output logic [15:0]   first_err_idx_o,
  output logic [WL-1:0] first_err_data_o,
  output logic          err_seen_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [15:0]   SEED       = 16'hACE1;
  localparam logic [15:0]   LAST_CNT   = 16'(NUM_VECT);
  localparam int            DW         = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(LAT - 1);

  // Fibonacci LFSR, taps 16,14,13,11, feedback enters bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  logic [1:0]    state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          add_en_q, add_en_d;
  logic [WL-1:0] op_x_q, op_x_d;
  logic [WL-1:0] op_y_q, op_y_d;
  logic [15:0]   vect_cnt_q, vect_cnt_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          aborted_q, aborted_d;
  logic [15:0]   err_cnt_q, err_cnt_d;
  logic [15:0]   first_err_idx_q, first_err_idx_d;
  logic [WL-1:0] first_err_data_q, first_err_data_d;
  logic          err_seen_q, err_seen_d;

  logic          issue;
  logic          run_clr;
  logic          flush;
  logic [15:0]   issue_src;
  logic          busy;

  logic          pipe_vld_q [LAT];
  logic [WL-1:0] pipe_exp_q [LAT];
  logic [15:0]   pipe_idx_q [LAT];
  logic [WL-1:0] sum_w;
  logic          cmp_vld;
  logic          cmp_fail;

  assign busy  = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign sum_w = op_x_q + op_y_q;

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    vect_cnt_d = vect_cnt_q;
    drain_d    = drain_q;
    aborted_d  = aborted_q;
    issue      = 1'b0;
    run_clr    = 1'b0;
    flush      = 1'b0;
    issue_src  = lfsr_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_RUN;
          run_clr   = 1'b1;
          aborted_d = 1'b0;
          issue     = 1'b1;
          issue_src = SEED;
        end
      end
      S_RUN: begin
        if (abort_i) begin
          state_d   = S_IDLE;
          flush     = 1'b1;
          aborted_d = 1'b1;
        end else if (vect_cnt_q == LAST_CNT) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          issue = 1'b1;
        end
      end
      S_DRAIN: begin
        if (abort_i) begin
          state_d   = S_IDLE;
          flush     = 1'b1;
          aborted_d = 1'b1;
        end else if (drain_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Operands are registered on the issue edge, so vect_cnt counts vectors already on the bus.
    if (issue) begin
      lfsr_d     = lfsr_step(issue_src);
      vect_cnt_d = run_clr ? 16'd1 : vect_cnt_q + 16'd1;
    end
    add_en_d = issue;
    op_x_d   = issue ? issue_src[WL-1:0]  : '0;
    op_y_d   = issue ? issue_src[15:16-WL] : '0;
  end

  assign cmp_vld  = pipe_vld_q[LAT-1] && busy && !abort_i;
  assign cmp_fail = cmp_vld && (add_result_i != pipe_exp_q[LAT-1]);

  always_comb begin
    err_cnt_d        = err_cnt_q;
    first_err_idx_d  = first_err_idx_q;
    first_err_data_d = first_err_data_q;
    err_seen_d       = err_seen_q;
    if (run_clr) begin
      err_cnt_d        = '0;
      first_err_idx_d  = '0;
      first_err_data_d = '0;
      err_seen_d       = 1'b0;
    end else if (cmp_fail) begin
      if (err_cnt_q != 16'hFFFF) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
      if (!err_seen_q) begin
        first_err_idx_d  = pipe_idx_q[LAT-1];
        first_err_data_d = add_result_i;
        err_seen_d       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= S_IDLE;
      lfsr_q           <= SEED;
      add_en_q         <= 1'b0;
      op_x_q           <= '0;
      op_y_q           <= '0;
      vect_cnt_q       <= '0;
      drain_q          <= '0;
      aborted_q        <= 1'b0;
      err_cnt_q        <= '0;
      first_err_idx_q  <= '0;
      first_err_data_q <= '0;
      err_seen_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      lfsr_q           <= lfsr_d;
      add_en_q         <= add_en_d;
      op_x_q           <= op_x_d;
      op_y_q           <= op_y_d;
      vect_cnt_q       <= vect_cnt_d;
      drain_q          <= drain_d;
      aborted_q        <= aborted_d;
      err_cnt_q        <= err_cnt_d;
      first_err_idx_q  <= first_err_idx_d;
      first_err_data_q <= first_err_data_d;
      err_seen_q       <= err_seen_d;
    end
  end

  // Expected sums enter one edge after the operands leave, matching the adder's own register stage.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_exp_q[i] <= '0;
        pipe_idx_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= add_en_q;
      pipe_exp_q[0] <= sum_w;
      pipe_idx_q[0] <= vect_cnt_q - 16'd1;
      for (int i = 1; i < LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_exp_q[i] <= pipe_exp_q[i-1];
        pipe_idx_q[i] <= pipe_idx_q[i-1];
      end
    end
  end

  assign add_en_o         = add_en_q;
  assign op_x_o           = op_x_q;
  assign op_y_o           = op_y_q;
  assign busy_o           = busy;
  assign done_o           = (state_q == S_DONE);
  assign aborted_o        = aborted_q;
  assign err_cnt_o        = err_cnt_q;
  assign vect_cnt_o       = vect_cnt_q;
  assign first_err_idx_o  = first_err_idx_q;
  assign first_err_data_o = first_err_data_q;
  assign err_seen_o       = err_seen_q;

endmodule

// File: tb/tb_adder_test_ctrl.sv
// Bench for adder_test_ctrl: four instances with different LAT/NUM_VECT, each fed by an adder model.
module tb_adder_test_ctrl;

  localparam int NI = 4;
  localparam int LATS [NI] = '{1, 1, 1, 3};
  localparam int NVS  [NI] = '{4, 16, 256, 8};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rst_s, start_s, abort_s, fault_on, stuck;

  wire        add_en_w  [NI];
  wire [7:0]  op_x_w    [NI];
  wire [7:0]  op_y_w    [NI];
  wire [7:0]  add_res_w [NI];
  wire        busy_w    [NI];
  wire        done_w    [NI];
  wire        aborted_w [NI];
  wire [15:0] err_cnt_w [NI];
  wire [15:0] vect_cnt_w[NI];
  wire [15:0] fei_w     [NI];
  wire [7:0]  fed_w     [NI];
  wire        seen_w    [NI];

  int checks = 0;
  int errors = 0;
  logic [15:0] sb_q [$];

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    localparam int L = LATS[g];
    logic [7:0]  ms [L];
    logic [15:0] mt [L];
    logic [15:0] mc;

    adder_test_ctrl #(.WL(8), .LAT(L), .NUM_VECT(NVS[g])) u_dut (
      .clk_i(clk), .rst_i(rst_s[g]), .start_i(start_s[g]), .abort_i(abort_s[g]),
      .add_en_o(add_en_w[g]), .op_x_o(op_x_w[g]), .op_y_o(op_y_w[g]),
      .add_result_i(add_res_w[g]), .busy_o(busy_w[g]), .done_o(done_w[g]),
      .aborted_o(aborted_w[g]), .err_cnt_o(err_cnt_w[g]), .vect_cnt_o(vect_cnt_w[g]),
      .first_err_idx_o(fei_w[g]), .first_err_data_o(fed_w[g]), .err_seen_o(seen_w[g])
    );

    // L-stage adder; mt tags each sum with its position in the burst for fault injection.
    always_ff @(posedge clk) begin
      mc    <= add_en_w[g] ? mc + 16'd1 : 16'd0;
      ms[0] <= op_x_w[g] + op_y_w[g];
      mt[0] <= mc;
      for (int k = 1; k < L; k++) begin
        ms[k] <= ms[k-1];
        mt[k] <= mt[k-1];
      end
    end
    assign add_res_w[g] = stuck[g] ? 8'h00 :
                          (ms[L-1] ^ ((fault_on[g] && mt[L-1] == 16'd2) ? 8'h01 : 8'h00));
  end

  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] l;
    l = 16'hACE1;
    for (int k = 0; k < n; k++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    return l;
  endfunction

  function automatic logic [7:0] golden_sum(input int n);
    logic [15:0] l;
    l = lfsr_at(n);
    return l[7:0] + l[15:8];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts a run on instance g; cycle c is sampled at the negedge inside it.
  task automatic run(input int g, input int stop_at, input int abort_at,
                     input int busy_start_at, input int rst_at, output int done_cyc);
    int nv;
    int idx;
    logic [15:0] l;
    logic [15:0] e;
    nv       = NVS[g];
    done_cyc = -1;
    idx      = 0;
    sb_q.delete();
    @(negedge clk);
    for (int i = 0; i < nv; i++) begin
      l = lfsr_at(i);
      sb_q.push_back({l[7:0], l[15:8]});
    end
    start_s[g] = 1'b1;
    abort_s[g] = (abort_at == 0);
    @(posedge clk);
    for (int c = 1; c <= nv + LATS[g] + 30; c++) begin
      @(negedge clk);
      start_s[g] = 1'b0;
      abort_s[g] = 1'b0;
      rst_s[g]   = 1'b0;
      if (c == 1) begin
        chk("busy_after_start", 32'(busy_w[g]), 32'd1);
        chk("aborted_cleared", 32'(aborted_w[g]), 32'd0);
      end
      if (add_en_w[g]) begin
        chk("vec_expected", 32'(sb_q.size() > 0), 32'd1);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 16'h0000;
        chk("vec_cycle", 32'(c), 32'(idx + 1));
        chk("vec_ops", 32'({op_x_w[g], op_y_w[g]}), 32'(e));
        idx++;
      end
      if (done_w[g]) begin
        done_cyc = c;
        break;
      end
      if (c == stop_at) break;
      if (c == abort_at)      abort_s[g] = 1'b1;
      if (c == busy_start_at) start_s[g] = 1'b1;
      if (c == rst_at)        rst_s[g]   = 1'b1;
    end
  endtask

  typedef struct {
    int         g;
    bit         fault;
    bit         stk;
    bit         with_abort;
    int         exp_done;
    int         exp_err;
    int         exp_idx;
    logic [7:0] exp_data;
    logic       exp_seen;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int dc;
    int nz;
    int first_nz;
    int pulses;

    nz = 0;
    first_nz = -1;
    for (int i = 0; i < NVS[1]; i++) begin
      if (golden_sum(i) != 8'h00) begin
        nz++;
        if (first_nz < 0) first_nz = i;
      end
    end
    tbl[0] = '{g:0, fault:0, stk:0, with_abort:0, exp_done:6,  exp_err:0, exp_idx:0,
               exp_data:8'h00, exp_seen:1'b0};
    tbl[1] = '{g:0, fault:1, stk:0, with_abort:0, exp_done:6,  exp_err:1, exp_idx:2,
               exp_data:golden_sum(2) ^ 8'h01, exp_seen:1'b1};
    tbl[2] = '{g:1, fault:0, stk:1, with_abort:0, exp_done:18, exp_err:nz, exp_idx:first_nz,
               exp_data:8'h00, exp_seen:(nz > 0)};
    tbl[3] = '{g:3, fault:0, stk:0, with_abort:1, exp_done:12, exp_err:0, exp_idx:0,
               exp_data:8'h00, exp_seen:1'b0};

    rst_s = '1; start_s = '0; abort_s = '0; fault_on = '0; stuck = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'(|{add_en_w[0], op_x_w[0], op_y_w[0], busy_w[0], done_w[0],
        aborted_w[0], err_cnt_w[0], vect_cnt_w[0], fei_w[0], fed_w[0], seen_w[0]}), 32'd0);
    rst_s = '0;
    repeat (2) @(negedge clk);

    foreach (tbl[t]) begin
      fault_on[tbl[t].g] = tbl[t].fault;
      stuck[tbl[t].g]    = tbl[t].stk;
      run(tbl[t].g, 0, tbl[t].with_abort ? 0 : -1, -1, -1, dc);
      chk("done_cycle", 32'(dc), 32'(tbl[t].exp_done));
      chk("busy_at_done", 32'(busy_w[tbl[t].g]), 32'd0);
      chk("err_cnt", 32'(err_cnt_w[tbl[t].g]), 32'(tbl[t].exp_err));
      chk("vect_cnt", 32'(vect_cnt_w[tbl[t].g]), 32'(NVS[tbl[t].g]));
      chk("err_seen", 32'(seen_w[tbl[t].g]), 32'(tbl[t].exp_seen));
      chk("first_err_idx", 32'(fei_w[tbl[t].g]), 32'(tbl[t].exp_idx));
      chk("first_err_data", 32'(fed_w[tbl[t].g]), 32'(tbl[t].exp_data));
      @(negedge clk);
      chk("done_one_cycle", 32'(done_w[tbl[t].g]), 32'd0);
      fault_on[tbl[t].g] = 1'b0;
      stuck[tbl[t].g]    = 1'b0;
      repeat (2) @(negedge clk);
    end

    // Abort after vector 9; the instance must go quiet and never signal done.
    run(2, 11, 10, -1, -1, dc);
    chk("abort_no_done_in_run", 32'(dc), 32'hFFFF_FFFF);
    chk("abort_add_en", 32'(add_en_w[2]), 32'd0);
    chk("abort_busy", 32'(busy_w[2]), 32'd0);
    chk("abort_flag", 32'(aborted_w[2]), 32'd1);
    chk("abort_vect_cnt", 32'(vect_cnt_w[2]), 32'd10);
    pulses = 0;
    repeat (300) begin
      @(negedge clk);
      if (done_w[2]) pulses++;
    end
    chk("abort_done_pulses", 32'(pulses), 32'd0);
    chk("abort_sticky", 32'(aborted_w[2]), 32'd1);
    chk("abort_vect_frozen", 32'(vect_cnt_w[2]), 32'd10);

    run(2, 0, -1, -1, -1, dc);
    chk("full_done_cycle", 32'(dc), 32'(NVS[2] + 2));
    chk("full_err_cnt", 32'(err_cnt_w[2]), 32'd0);
    chk("full_vect_cnt", 32'(vect_cnt_w[2]), 32'(NVS[2]));

    // A start while busy must not restart the run.
    repeat (2) @(negedge clk);
    run(0, 0, -1, 3, -1, dc);
    chk("busy_start_done", 32'(dc), 32'd6);
    chk("busy_start_vect", 32'(vect_cnt_w[0]), 32'd4);

    repeat (2) @(negedge clk);
    fault_on[0] = 1'b1;
    run(0, 6, -1, -1, 5, dc);
    chk("rst_no_done", 32'(dc), 32'hFFFF_FFFF);
    chk("rst_outputs", 32'(|{add_en_w[0], op_x_w[0], op_y_w[0], busy_w[0], done_w[0],
        aborted_w[0], err_cnt_w[0], vect_cnt_w[0], fei_w[0], fed_w[0], seen_w[0]}), 32'd0);
    fault_on[0] = 1'b0;
    repeat (2) @(negedge clk);
    run(0, 0, -1, -1, -1, dc);
    chk("post_rst_done", 32'(dc), 32'd6);
    chk("post_rst_err", 32'(err_cnt_w[0]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
